// File: rtl/hack_pkg.sv
// Shared definitions for the Hack fetch path: default PC geometry and the
// per-cycle operation chosen by the program-counter priority encoder.
package hack_pkg;
   localparam int HACK_PC_W      = 16;
   localparam int HACK_RESET_VEC = 0;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_RET,
      PC_CALL,
      PC_LOAD,
      PC_INC
   } pc_op_t;
endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with a combinational top-of-stack read.
// A push while full or a pop while empty is ignored.
module ret_stack #(
   parameter  int DEPTH = 8,
   parameter  int W     = 16,
   localparam int DW    = $clog2(DEPTH + 1),
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [DW-1:0] cnt;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;

   assign wr_idx = cnt[AW-1:0];
   assign rd_idx = AW'(cnt - 1'b1);
   assign full   = (cnt == DW'(DEPTH));
   assign empty  = (cnt == '0);
   assign depth  = cnt;
   // rd_idx is meaningless when empty, so the read is masked rather than
   // allowed to index past the array for non-power-of-two depths.
   assign dout   = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (push && !full) begin
         cnt <= cnt + 1'b1;
      end else if (pop && !empty) begin
         cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_idx] <= din;
      end
   end
endmodule

// File: rtl/pc_call_stack.sv
// Program counter with stall, jump, and call/return through a hardware
// return-address stack; flags overflow/underflow in a sticky error bit.
module pc_call_stack
   import hack_pkg::*;
#(
   parameter int              PC_W        = HACK_PC_W,
   parameter int              STACK_DEPTH = 8,
   parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(HACK_RESET_VEC)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               stall,
   input  logic                               PC_we,
   input  logic [PC_W-1:0]                    PC_in,
   input  logic                               call,
   input  logic                               ret,
   input  logic                               err_clr,
   output logic [PC_W-1:0]                    PC_out,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic                               stack_err
);
   pc_op_t          op;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W-1:0] tos;
   logic            push;
   logic            pop;
   logic            err_set;

   assign pc_inc = PC_out + 1'b1;

   ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (tos),
      .depth (stack_depth),
      .full  (stack_full),
      .empty (stack_empty)
   );

   always_comb begin
      op = PC_INC;
      if (stall)      op = PC_HOLD;
      else if (ret)   op = PC_RET;
      else if (call)  op = PC_CALL;
      else if (PC_we) op = PC_LOAD;
   end

   always_comb begin
      pc_nxt  = PC_out;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      unique case (op)
         PC_HOLD: pc_nxt = PC_out;
         PC_RET: begin
            if (stack_empty) begin
               pc_nxt  = pc_inc;
               err_set = 1'b1;
            end else begin
               pc_nxt = tos;
               pop    = 1'b1;
            end
         end
         PC_CALL: begin
            // The jump is taken even when the push is lost to overflow.
            pc_nxt = PC_in;
            if (stack_full) err_set = 1'b1;
            else            push    = 1'b1;
         end
         PC_LOAD: pc_nxt = PC_in;
         PC_INC:  pc_nxt = pc_inc;
         default: pc_nxt = PC_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         PC_out    <= RESET_VEC;
         stack_err <= 1'b0;
      end else begin
         PC_out <= pc_nxt;
         if (err_set)      stack_err <= 1'b1;
         else if (err_clr) stack_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed scoreboard bench for pc_call_stack: default instance (16-bit, depth 8)
// and a small instance (12-bit, depth 4, reset vector 0x100).
module tb_pc_call_stack;
   logic clk;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          due;
      string       name;
      logic [15:0] pc;
      int          depth;
      bit          full;
      bit          empty;
      bit          err;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   logic        a_rst, a_stall, a_we, a_call, a_ret, a_clr;
   logic [15:0] a_pcin, a_pc;
   logic [3:0]  a_depth;
   logic        a_full, a_empty, a_err;

   logic        b_rst, b_stall, b_we, b_call, b_ret, b_clr;
   logic [11:0] b_pcin, b_pc;
   logic [2:0]  b_depth;
   logic        b_full, b_empty, b_err;

   pc_call_stack dut_a (
      .clk         (clk),
      .reset       (a_rst),
      .stall       (a_stall),
      .PC_we       (a_we),
      .PC_in       (a_pcin),
      .call        (a_call),
      .ret         (a_ret),
      .err_clr     (a_clr),
      .PC_out      (a_pc),
      .stack_depth (a_depth),
      .stack_full  (a_full),
      .stack_empty (a_empty),
      .stack_err   (a_err)
   );

   pc_call_stack #(
      .PC_W        (12),
      .STACK_DEPTH (4),
      .RESET_VEC   (12'h100)
   ) dut_b (
      .clk         (clk),
      .reset       (b_rst),
      .stall       (b_stall),
      .PC_we       (b_we),
      .PC_in       (b_pcin),
      .call        (b_call),
      .ret         (b_ret),
      .err_clr     (b_clr),
      .PC_out      (b_pc),
      .stack_depth (b_depth),
      .stack_full  (b_full),
      .stack_empty (b_empty),
      .stack_err   (b_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string inst, input exp_t e, input logic [15:0] pc,
                      input int dep, input logic fl, input logic em, input logic er);
      total++;
      if (pc !== e.pc || dep != e.depth || fl !== e.full || em !== e.empty || er !== e.err) begin
         bad++;
         $display("FAIL %s/%s: got pc=%h depth=%0d full=%b empty=%b err=%b, want pc=%h depth=%0d full=%b empty=%b err=%b",
                  inst, e.name, pc, dep, fl, em, er, e.pc, e.depth, e.full, e.empty, e.err);
      end
   endtask

   // Monitor: an output is due one edge after its stimulus was applied.
   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() > 0 && q_a[0].due == cyc) begin
         e = q_a.pop_front();
         chk("a", e, a_pc, int'(a_depth), a_full, a_empty, a_err);
      end
      if (q_b.size() > 0 && q_b[0].due == cyc) begin
         e = q_b.pop_front();
         chk("b", e, {4'h0, b_pc}, int'(b_depth), b_full, b_empty, b_err);
      end
   end

   task automatic drive(input bit inst_b, input string nm, input bit rs, input bit st,
                        input bit r, input bit c, input bit we, input bit clr,
                        input logic [15:0] pin, input logic [15:0] epc,
                        input int edep, input bit eerr);
      exp_t e;
      @(posedge clk);
      #1;
      e.due   = cyc + 1;
      e.name  = nm;
      e.pc    = epc;
      e.depth = edep;
      e.full  = (edep == (inst_b ? 4 : 8));
      e.empty = (edep == 0);
      e.err   = eerr;
      if (!inst_b) begin
         a_rst = rs; a_stall = st; a_ret = r; a_call = c; a_we = we; a_clr = clr; a_pcin = pin;
         q_a.push_back(e);
      end else begin
         b_rst = rs; b_stall = st; b_ret = r; b_call = c; b_we = we; b_clr = clr; b_pcin = pin[11:0];
         q_b.push_back(e);
      end
   endtask

   task automatic idle(input bit inst_b, input string nm, input logic [15:0] epc,
                       input int edep, input bit eerr);
      drive(inst_b, nm, 0, 0, 0, 0, 0, 0, 16'h0, epc, edep, eerr);
   endtask

   initial begin
      a_rst = 1; a_stall = 0; a_we = 0; a_call = 0; a_ret = 0; a_clr = 0; a_pcin = '0;
      b_rst = 1; b_stall = 0; b_we = 0; b_call = 0; b_ret = 0; b_clr = 0; b_pcin = '0;

      // Reset and free-running increment
      drive(0, "reset", 1, 0, 0, 0, 0, 0, 16'h0, 16'h0000, 0, 0);
      for (int i = 1; i <= 5; i++) idle(0, "inc", 16'(i), 0, 0);

      // Simple call / return
      drive(0, "jump", 0, 0, 0, 0, 1, 0, 16'h0010, 16'h0010, 0, 0);
      drive(0, "call", 0, 0, 0, 1, 0, 0, 16'h0200, 16'h0200, 1, 0);
      idle(0, "sub_inc1", 16'h0201, 1, 0);
      idle(0, "sub_inc2", 16'h0202, 1, 0);
      drive(0, "ret", 0, 0, 1, 0, 0, 0, 16'h0, 16'h0011, 0, 0);

      // Nest to full, overflow, unwind in LIFO order
      for (int i = 1; i <= 8; i++)
         drive(0, "nest_call", 0, 0, 0, 1, 0, 0, 16'(i << 8), 16'(i << 8), i, 0);
      drive(0, "overflow", 0, 0, 0, 1, 0, 0, 16'h0900, 16'h0900, 8, 1);
      for (int k = 8; k >= 1; k--)
         drive(0, "unwind", 0, 0, 1, 0, 0, 0, 16'h0,
               (k == 1) ? 16'h0012 : 16'(((k - 1) << 8) | 1), k - 1, 1);
      drive(0, "clr_after_ovf", 0, 0, 0, 0, 0, 1, 16'h0, 16'h0013, 0, 0);

      // Underflow and sticky error behaviour
      drive(0, "jump40", 0, 0, 0, 0, 1, 0, 16'h0040, 16'h0040, 0, 0);
      drive(0, "underflow", 0, 0, 1, 0, 0, 0, 16'h0, 16'h0041, 0, 1);
      drive(0, "err_clr", 0, 0, 0, 0, 0, 1, 16'h0, 16'h0042, 0, 0);
      drive(0, "clr_vs_set", 0, 0, 1, 0, 0, 1, 16'h0, 16'h0043, 0, 1);
      drive(0, "err_clr2", 0, 0, 0, 0, 0, 1, 16'h0, 16'h0044, 0, 0);
      drive(0, "call300", 0, 0, 0, 1, 0, 0, 16'h0300, 16'h0300, 1, 0);
      drive(0, "ret_beats_call", 0, 0, 1, 1, 1, 0, 16'h0555, 16'h0045, 0, 0);

      // Wrap and stall
      drive(0, "jumpffff", 0, 0, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
      idle(0, "wrap", 16'h0000, 0, 0);
      drive(0, "call5", 0, 0, 0, 1, 0, 0, 16'h0005, 16'h0005, 1, 0);
      drive(0, "stall_call", 0, 1, 0, 1, 0, 0, 16'h0777, 16'h0005, 1, 0);
      drive(0, "stall_ret", 0, 1, 1, 0, 0, 0, 16'h0777, 16'h0005, 1, 0);
      drive(0, "stall_we", 0, 1, 0, 1, 1, 0, 16'h0777, 16'h0005, 1, 0);
      drive(0, "ret_after_stall", 0, 0, 1, 0, 0, 0, 16'h0, 16'h0001, 0, 0);

      // Reset in the middle of a call sequence
      drive(0, "uf_before_rst", 0, 0, 1, 0, 0, 0, 16'h0, 16'h0002, 0, 1);
      drive(0, "c10", 0, 0, 0, 1, 0, 0, 16'h0010, 16'h0010, 1, 1);
      drive(0, "c20", 0, 0, 0, 1, 0, 0, 16'h0020, 16'h0020, 2, 1);
      drive(0, "c30", 0, 0, 0, 1, 0, 0, 16'h0030, 16'h0030, 3, 1);
      drive(0, "reset_with_ret", 1, 0, 1, 0, 0, 0, 16'h0, 16'h0000, 0, 0);
      idle(0, "post_reset", 16'h0001, 0, 0);

      // Small configuration: reset vector, increment, nest/overflow/unwind, wrap
      drive(1, "reset", 1, 0, 0, 0, 0, 0, 16'h0, 16'h0100, 0, 0);
      for (int i = 1; i <= 5; i++) idle(1, "inc", 16'(16'h0100 + i), 0, 0);
      for (int i = 1; i <= 4; i++)
         drive(1, "nest_call", 0, 0, 0, 1, 0, 0, 16'(i << 8), 16'(i << 8), i, 0);
      drive(1, "overflow", 0, 0, 0, 1, 0, 0, 16'h0500, 16'h0500, 4, 1);
      for (int k = 4; k >= 1; k--)
         drive(1, "unwind", 0, 0, 1, 0, 0, 0, 16'h0,
               (k == 1) ? 16'h0106 : 16'(((k - 1) << 8) | 1), k - 1, 1);
      drive(1, "jumpfff", 0, 0, 0, 0, 1, 1, 16'h0FFF, 16'h0FFF, 0, 0);
      idle(1, "wrap", 16'h0000, 0, 0);

      for (int n = 0; n < 5 && (q_a.size() > 0 || q_b.size() > 0); n++) @(posedge clk);
      @(negedge clk);
      #1;
      if (q_a.size() > 0 || q_b.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
